// File: rtl/muldiv_sequencer_if.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer_if
//   EX-stage handshake between the pipeline and the iterative RV32M
//   multiply/divide sequencer.
//
//   master (EX stage / hazard unit):
//     StartE, Fn3E, Op1E, Op2E, FlushE  -> sequencer
//     MulDivStall, Busy, Done, Result   <- sequencer
//   slave (muldiv_sequencer): the mirror image of master.
// ----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StartE;
    logic [2:0]            Fn3E;
    logic [DATA_WIDTH-1:0] Op1E;
    logic [DATA_WIDTH-1:0] Op2E;
    logic                  FlushE;
    logic                  MulDivStall;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output StartE, Fn3E, Op1E, Op2E, FlushE,
        input  MulDivStall, Busy, Done, Result
    );

    modport slave (
        input  StartE, Fn3E, Op1E, Op2E, FlushE,
        output MulDivStall, Busy, Done, Result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative RV32M multiply/divide engine for the EX stage. One M-extension
//   operation is accepted from EX and runs for DATA_WIDTH CALC cycles
//   (radix-2 shift-add multiply or restoring divide), then a single FIN cycle
//   presents the registered Result with a one-cycle Done pulse. Divide by zero
//   and signed overflow skip CALC and go straight to FIN.
//
// Ports:
//   CPU_CLK   clock, rising edge
//   CPU_RSTN  asynchronous active-low reset
//   bus       muldiv_sequencer_if.slave
//               StartE/Fn3E/Op1E/Op2E  operation request from EX
//               FlushE                 kill the EX instruction / abort
//               MulDivStall            stall request for IF/ID/EX
//               Busy                   state is CALC or FIN
//               Done                   one-cycle pulse, Result valid
//               Result                 registered result
// ----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input logic              CPU_CLK,
    input logic              CPU_RSTN,
    muldiv_sequencer_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     fn3_q;
    logic [W-1:0]   opa;        // multiplicand, or divisor magnitude
    logic [2*W-1:0] acc;        // {product hi, multiplier} or {remainder, quotient}
    logic           sign_res;   // product / quotient sign
    logic           sign_rem;   // remainder sign (sign of Op1)
    logic [W-1:0]   result_q;
    logic           done_q;
    logic           busy_q;

    // ---------------- request decode (IDLE) ----------------
    logic         is_div_in, op1_signed, op2_signed, neg1, neg2;
    logic [W-1:0] mag1, mag2, special_res;
    logic         div_zero, div_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        is_div_in   = bus.Fn3E[2];
        op1_signed  = (bus.Fn3E == 3'b001) || (bus.Fn3E == 3'b010) ||
                      (bus.Fn3E == 3'b100) || (bus.Fn3E == 3'b110);
        op2_signed  = (bus.Fn3E == 3'b001) || (bus.Fn3E == 3'b100) ||
                      (bus.Fn3E == 3'b110);
        neg1        = op1_signed && bus.Op1E[W-1];
        neg2        = op2_signed && bus.Op2E[W-1];
        mag1        = neg1 ? -bus.Op1E : bus.Op1E;
        mag2        = neg2 ? -bus.Op2E : bus.Op2E;
        div_zero    = is_div_in && (bus.Op2E == '0);
        // Signed overflow only exists for DIV/REM (funct3 1x0).
        div_ovf     = is_div_in && !bus.Fn3E[0] &&
                      (bus.Op1E == {1'b1, {(W-1){1'b0}}}) && (bus.Op2E == '1);
        special_res = '0;
        if (div_zero)
            special_res = bus.Fn3E[1] ? bus.Op1E : '1;
        else if (div_ovf)
            special_res = bus.Fn3E[1] ? '0 : bus.Op1E;
    end

    // ---------------- one iteration (CALC) ----------------
    logic [W:0]     sum, shifted, trial;
    logic [2*W-1:0] acc_nxt, prod;
    logic [W-1:0]   quo, rem, res_nxt;

    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : '0);
        shifted = {acc[2*W-1:W], acc[W-1]};
        trial   = shifted - {1'b0, opa};
        if (!fn3_q[2])
            acc_nxt = {sum, acc[W-1:1]};
        else if (!trial[W])
            acc_nxt = {trial[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_nxt = {shifted[W-1:0], acc[W-2:0], 1'b0};

        prod = sign_res ? -acc_nxt : acc_nxt;
        quo  = acc_nxt[W-1:0];
        rem  = acc_nxt[2*W-1:W];
        if (!fn3_q[2])
            res_nxt = (fn3_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (fn3_q[1])
            res_nxt = sign_rem ? -rem : rem;
        else
            res_nxt = sign_res ? -quo : quo;
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge CPU_CLK or negedge CPU_RSTN) begin
        if (!CPU_RSTN) begin
            state    <= IDLE;
            cnt      <= '0;
            fn3_q    <= '0;
            opa      <= '0;
            acc      <= '0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            if (bus.FlushE) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.StartE) begin
                            fn3_q    <= bus.Fn3E;
                            opa      <= is_div_in ? mag2 : mag1;
                            acc      <= {{W{1'b0}}, (is_div_in ? mag1 : mag2)};
                            sign_res <= neg1 ^ neg2;
                            sign_rem <= neg1;
                            cnt      <= '0;
                            busy_q   <= 1'b1;
                            if (div_zero || div_ovf) begin
                                result_q <= special_res;
                                done_q   <= 1'b1;
                                state    <= FIN;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(W-1)) begin
                            result_q <= res_nxt;
                            done_q   <= 1'b1;
                            state    <= FIN;
                        end
                    end
                    FIN: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stall is combinational so EX freezes in the very cycle the op is
    // accepted; it drops at once on flush or reset.
    assign bus.MulDivStall = CPU_RSTN && !bus.FlushE &&
                             (((state == IDLE) && bus.StartE) || (state == CALC));
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer. Expected results and latencies
//   are pushed to a scoreboard queue when an operation is issued and popped
//   when Done is seen.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    logic CPU_CLK;
    logic CPU_RSTN;
    muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .CPU_CLK (CPU_CLK),
        .CPU_RSTN(CPU_RSTN),
        .bus     (bus)
    );

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] last_res = '0;

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference model of the RV32M operations.
    function automatic logic [W-1:0] model(input logic [2:0] fn3,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        p;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (fn3)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin sa = $signed(a); sb = $signed(b); p = sa * sb; return p[63:32]; end
            3'b010: begin sa = $signed(a); sb = {32'b0, b}; p = sa * sb; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        bus.Fn3E   = 3'b000;
        bus.Op1E   = '0;
        bus.Op2E   = '0;
    endtask

    // Issue one operation, hold StartE through the stall, score the result.
    task automatic run_op(input string name, input logic [2:0] fn3,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res);
        exp_t e;
        exp_t got_e;
        int   cycles, stall_cnt;
        bit   got;
        e.res = exp_res;
        e.lat = (fn3[2] && ((b == 0) ||
                 (!fn3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : W + 2;
        sb_q.push_back(e);

        @(negedge CPU_CLK);
        bus.StartE = 1'b1;
        bus.Fn3E   = fn3;
        bus.Op1E   = a;
        bus.Op2E   = b;
        #1;
        checks++;
        if (bus.MulDivStall !== 1'b1) begin
            failures++;
            $display("FAIL %s stall_on_accept: got %b want 1", name, bus.MulDivStall);
        end
        cycles = 1; stall_cnt = 1; got = 0;
        while (!got && cycles < 100) begin
            @(posedge CPU_CLK); #1;
            cycles++;
            if (bus.Done === 1'b1) got = 1;
            else begin
                if (bus.MulDivStall === 1'b1) stall_cnt++;
                checks++;
                if (bus.Busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_calc cycle %0d: got %b want 1", name, cycles, bus.Busy);
                end
            end
        end
        got_e = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s done_timeout: no Done within %0d cycles", name, cycles);
        end else begin
            if (bus.Result !== got_e.res) begin
                failures++;
                $display("FAIL %s result: got %h want %h", name, bus.Result, got_e.res);
            end
            checks++;
            if (cycles != got_e.lat) begin
                failures++;
                $display("FAIL %s latency: got %0d want %0d", name, cycles, got_e.lat);
            end
            checks++;
            if (stall_cnt != got_e.lat - 1) begin
                failures++;
                $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, got_e.lat - 1);
            end
            checks++;
            if (bus.MulDivStall !== 1'b0 || bus.Busy !== 1'b1) begin
                failures++;
                $display("FAIL %s fin_flags: stall=%b busy=%b want stall=0 busy=1",
                         name, bus.MulDivStall, bus.Busy);
            end
        end
        last_res = got_e.res;
        @(negedge CPU_CLK);
        bus.StartE = 1'b0;
        @(posedge CPU_CLK); #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== last_res) begin
            failures++;
            $display("FAIL %s after_fin: busy=%b done=%b result=%h want busy=0 done=0 result=%h",
                     name, bus.Busy, bus.Done, bus.Result, last_res);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        CPU_RSTN = 1'b0;
        repeat (3) @(posedge CPU_CLK);
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MulDivStall !== 1'b0 || bus.Result !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h want 0/0/0/0",
                     bus.Busy, bus.Done, bus.MulDivStall, bus.Result);
        end
        @(negedge CPU_CLK);
        CPU_RSTN = 1'b1;
        @(posedge CPU_CLK); #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b done=%b want 0/0", bus.Busy, bus.Done);
        end
    endtask

    task automatic test_mul();
        run_op("mul_7x-3", 3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    endtask

    task automatic test_mul_high();
        run_op("mulh_m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_op("div_-7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_-7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);
    endtask

    task automatic test_special();
        run_op("div_by0",  3'b100, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        run_op("rem_by0",  3'b110, 32'h1234, 32'h0, 32'h0000_1234);
        run_op("divu_by0", 3'b101, 32'h55,   32'h0, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'b111, 32'h55,   32'h0, 32'h0000_0055);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    endtask

    task automatic test_flush();
        // Flush while StartE is high in IDLE: no accept.
        @(negedge CPU_CLK);
        bus.StartE = 1'b1; bus.FlushE = 1'b1;
        bus.Fn3E = 3'b000; bus.Op1E = 32'd5; bus.Op2E = 32'd6;
        #1;
        checks++;
        if (bus.MulDivStall !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_stall: got %b want 0", bus.MulDivStall);
        end
        @(posedge CPU_CLK); #1;
        checks++;
        if (bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_accept: busy=%b want 0", bus.Busy);
        end
        // Accept, then flush at CALC iteration 10.
        @(negedge CPU_CLK);
        bus.FlushE = 1'b0;
        repeat (10) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        bus.FlushE = 1'b1;
        #1;
        checks++;
        if (bus.MulDivStall !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc_stall: got %b want 0", bus.MulDivStall);
        end
        @(posedge CPU_CLK); #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== last_res) begin
            failures++;
            $display("FAIL flush_calc_abort: busy=%b done=%b result=%h want 0/0/%h",
                     bus.Busy, bus.Done, bus.Result, last_res);
        end
        @(negedge CPU_CLK);
        idle_inputs();
        // Make sure the aborted op never produces a late Done.
        for (int i = 0; i < 40; i++) begin
            @(posedge CPU_CLK); #1;
            if (bus.Done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL flush_late_done: Done seen %0d cycles after flush", i);
                break;
            end
        end
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mul",  3'b000, 32'd1000, 32'd1000, 32'd1_000_000);
        run_op("b2b_div",  3'b100, 32'hFFFF_FC18, 32'd10, 32'hFFFF_FF9C);
        run_op("b2b_remu", 3'b111, 32'hDEAD_BEEF, 32'h1_0000, 32'h0000_BEEF);
    endtask

    task automatic test_random();
        logic [2:0] fn3;
        logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            fn3 = 3'(i % 8);
            a   = $urandom;
            b   = (i == 13) ? 32'h0 : $urandom >> (i % 5) * 7;
            run_op($sformatf("rand%0d_fn%0d", i, fn3), fn3, a, b, model(fn3, a, b));
        end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge CPU_CLK);
        bus.StartE = 1'b1; bus.Fn3E = 3'b000;
        bus.Op1E = 32'h1234_5678; bus.Op2E = 32'h9ABC_DEF0;
        repeat (6) @(posedge CPU_CLK);
        #3;
        CPU_RSTN = 1'b0;
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MulDivStall !== 1'b0 || bus.Result !== '0) begin
            failures++;
            $display("FAIL reset_mid_calc: busy=%b done=%b stall=%b result=%h want 0/0/0/0",
                     bus.Busy, bus.Done, bus.MulDivStall, bus.Result);
        end
        idle_inputs();
        @(negedge CPU_CLK);
        CPU_RSTN = 1'b1;
        last_res = '0;
        run_op("mulhu_2x3", 3'b011, 32'd2, 32'd3, 32'd0);
    endtask

    initial begin
        idle_inputs();
        CPU_RSTN = 1'b0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_calc();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide engine and its sequencing FSM, placed beside the ALU in the EX stage of the RISC-V pipeline CPU.
- Accepts one M-extension operation from EX and runs it over DATA_WIDTH cycles.
- Drives a stall request that freezes IF/ID/EX until the result is ready; honours EX flushes from branch/jump redirection.

Parameters:
DATA_WIDTH, 32, operand/result width; also the iteration count per operation.

Ports:
CPU_CLK  input  1  clock; all state updates on rising edge
CPU_RSTN  input  1  asynchronous active-low reset
StartE  input  1  EX holds a valid M-extension instruction
Fn3E  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Op1E  input  DATA_WIDTH  rs1 operand, already forwarded
Op2E  input  DATA_WIDTH  rs2 operand, already forwarded
FlushE  input  1  kill the EX instruction; aborts any operation in progress
MulDivStall  output  1  stall request to the hazard logic for IF/ID/EX
Busy  output  1  state is CALC or FIN
Done  output  1  one-cycle pulse; Result valid for the EX instruction
Result  output  DATA_WIDTH  registered result; held until the next accepted operation

Behaviour:
- Reset (async, CPU_RSTN=0): state IDLE; counter 0; internal operand, accumulator and sign registers 0; Result 0; Done 0; Busy 0. Reset mid-operation discards the operation, and no Done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - Operation is accepted when StartE=1 and FlushE=0.
  - On accept, latch Fn3E, the operand magnitudes and the result-sign flag, and clear the counter.
  - Next state is CALC, or FIN for the special cases below.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: Op1 signed, Op2 unsigned.
  - MUL/MULHU/DIVU/REMU: operands unsigned (MUL low word is sign-independent).
  - Magnitudes are taken by two's-complement negation.
- Multiply: radix-2 shift-add, one bit per CALC cycle, into a 2*DATA_WIDTH product. Negate the product if the sign flag is set. MUL selects the low word; MULH/MULHSU/MULHU select the high word.
- Divide: restoring division, one quotient bit per CALC cycle.
  - Quotient sign = sign(Op1) XOR sign(Op2).
  - Remainder sign = sign(Op1).
- Special cases, detected in IDLE and sent directly to FIN with the result precomputed:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give Op1.
  - Signed overflow (Op1=0x80000000, Op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle; counter increments. After iteration DATA_WIDTH (counter == DATA_WIDTH-1) go to FIN.
- FIN:
  - Result register is loaded on entry, so it is valid throughout FIN.
  - Done=1 for exactly this cycle.
  - Next state is IDLE unconditionally. StartE is ignored in FIN because the EX instruction retires at the end of this cycle.
- MulDivStall = (IDLE & StartE & ~FlushE) | CALC. This term is combinational from the inputs in IDLE. MulDivStall is 0 in FIN, so the pipeline advances and captures Result.
- Latency: accept at edge k; CALC from edge k+1 to edge k+DATA_WIDTH; FIN at cycle k+DATA_WIDTH+1. Normal ops take 34 cycles of EX occupancy for DATA_WIDTH=32. Special cases enter FIN at cycle k+1 (2 cycles).
- Flush: FlushE=1 in any state forces IDLE at the next edge. Done is not asserted, Result is unchanged, and MulDivStall drops in that same cycle. FlushE together with StartE in IDLE means no accept.
- Back-to-back: a new StartE in the cycle after FIN is accepted normally.

Test Plan:
- MUL 7 * -3 (Op1=0x7, Op2=0xFFFFFFFD, Fn3=000) -> MulDivStall high for 33 cycles; Done at cycle 34 with Result=0xFFFFFFEB; Busy low afterwards.
- MULH / MULHSU / MULHU with Op1=Op2=0xFFFFFFFF -> Result 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with Op1=0x1234 -> 0xFFFFFFFF; REM x/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each of these has Done at cycle 2.
- FlushE pulsed at CALC iteration 10 -> IDLE next edge, no Done, Result keeps its prior value. A fresh DIVU 9/3 then completes with Result 3.
- CPU_RSTN asserted mid-CALC (asynchronously, between edges) -> Busy/Done/MulDivStall go to 0 immediately, Result goes to 0. After release, MULHU 2*3 -> Result 0.
